ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), to a keyboard or mouse over the shared open-drain PS/2 clock and data pins.
- Sits beside ps2_keyboard in the PS/2 peripheral, under the same Wishbone wrapper.
- Generates the inhibit/request-to-send sequence and shifts the frame out on device-generated clocks.
- Checks the device ack and reports done/error. Asserts rx_inhibit so the receiver ignores bus activity during the transmission.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles the host holds ps2_clk low (125 us at 96 MHz).
- TIMEOUT_CYCLES, 1920000: maximum clk cycles from REQ entry to the end of the ack (20 ms).
- FILTER_LEN, 4: consecutive identical synchronized samples required before the filtered ps2_clk changes state.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous abort; returns the FSM to IDLE
- start  in  1  one-cycle request to transmit data_in
- data_in  in  8  byte to send, latched on an accepted start
- busy  out  1  high from an accepted start until done
- done  out  1  one-cycle pulse at transaction end
- ack_ok  out  1  valid with done; 1 = device acked
- error  out  1  valid with done; 1 = nack or timeout
- rx_inhibit  out  1  equals busy; receiver discards frames while high
- ps2_clk  in  1  PS/2 clock pin (asynchronous)
- ps2_dat  in  1  PS/2 data pin (asynchronous)
- ps2_clk_drive_low  out  1  1 = pull the clock pin low (open-drain enable)
- ps2_dat_drive_low  out  1  1 = pull the data pin low

Behaviour:
- Reset (async or sync_reset): every output is 0, both pins are released, and the FSM is in IDLE. Reset releases the pins immediately even mid-frame. sync_reset has priority over start.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-flop synchronizer.
  - ps2_clk is then filtered: the filtered value changes only after FILTER_LEN equal consecutive samples.
  - fall = filtered 1->0 transition. Pin-to-fall latency is 2+FILTER_LEN cycles.
  - ps2_dat is sampled synchronized only, with no filter.
- Checksum: the parity bit is odd parity, computed as ~^data. Frame order after the start bit: d0..d7 (LSB first), parity, stop=1.
- FSM:
  - IDLE: all pins released. On start, latch data_in and go to INHIBIT; busy=1 from the next cycle. start is ignored while busy.
  - INHIBIT: ps2_clk_drive_low=1 for INHIBIT_CYCLES cycles. ps2_dat_drive_low also =1 during the final cycle. Then go to REQ.
  - REQ: clock released, data held low (start bit). Clear the timeout counter and the bit index (0). On fall, go to SEND and present bit index 0.
  - SEND: present the current bit as ps2_dat_drive_low = ~bit. The value changes only on fall, one bit per fall.
    - The presented sequence is d0..d7, parity, stop. The stop bit releases data.
    - On the fall after stop is presented (11th fall counted from REQ), sample ps2_dat. Low gives ack_ok, high gives nack. Go to RELEASE.
  - RELEASE: wait until the synchronized ps2_dat and the filtered ps2_clk are both 1, then go to DONE.
  - DONE (one cycle): done=1 and busy=0 next. ack_ok/error hold their result until the next accepted start, then clear on it.
- Timeout: the counter runs in REQ, SEND and RELEASE. When it reaches TIMEOUT_CYCLES: release both pins, set error=1 and ack_ok=0, pulse done, go to IDLE. A timeout on the same cycle as the ack sample resolves to timeout.
- ack_ok and error are never 1 together.
- Counter width is $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1). A single shared counter is permitted.
- Falls seen in IDLE or INHIBIT are ignored.

Test Plan (bench params: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, FILTER_LEN=2; device model clocks at a 40-cycle period, samples data on the rising edge, acks low):
- Send 0xED: 20 cycles of clk_drive_low, then the device samples start=0, data bits 1,0,1,1,0,1,1,1, parity=1, stop=1. Device acks -> done pulse with ack_ok=1, error=0; busy falls the cycle after done.
- Send 0x00: device samples eight 0 bits, parity=1 and stop=1. Send 0x01: parity=0.
- Device holds data high on the 11th fall (nack) -> done with ack_ok=0, error=1; pins released.
- Device never clocks after REQ -> done and error=1 exactly 2000 cycles after REQ entry; ps2_dat_drive_low returns to 0.
- start pulsed during SEND with 0x55 -> ignored; the frame still carries the original byte. A 1-cycle low glitch on ps2_clk -> no bit advance.
- sync_reset and, separately, reset_n asserted at bit 4 -> both drive_low outputs 0 and busy=0. A fresh start of 0xF4 then completes with ack_ok=1.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one byte to a keyboard/mouse: holds the clock low (inhibit), issues the
// request-to-send (data low, clock released), then shifts d0..d7, odd parity and
// stop out on device-generated clock falls and checks the device ack bit.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   sync_reset            synchronous abort back to IDLE (wins over start)
//   start, data_in[7:0]   one-cycle transmit request and the byte to send
//   busy                  high from an accepted start until done
//   done                  one-cycle pulse at transaction end
//   ack_ok, error         transaction result, valid with done, held until next start
//   rx_inhibit            equals busy; tells the receiver to discard bus traffic
//   ps2_clk, ps2_dat      asynchronous PS/2 pin inputs
//   ps2_clk_drive_low     1 = pull the clock pin low (open-drain enable)
//   ps2_dat_drive_low     1 = pull the data pin low (open-drain enable)
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 1920000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sync_reset,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error,
    output logic       rx_inhibit,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned FW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_RELEASE,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Pin conditioning: 2-flop synchronizers, clock glitch filter, fall pulse
    // ------------------------------------------------------------------
    logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic          clk_filt_q, clk_filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_dat;
            dat_sync_q <= dat_meta_q;
            clk_filt_q <= clk_filt_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_d;
        end
    end

    // The filtered clock flips on the FILTER_LEN-th consecutive sample that
    // disagrees with it; any agreeing sample restarts the run.
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        fall_d     = 1'b0;
        if (clk_sync_q != clk_filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                clk_filt_d = clk_sync_q;
                fall_d     = ~clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;      // inhibit length, then timeout
    logic [3:0]    idx_q, idx_d;      // index of the bit currently presented
    logic [9:0]    frame_q, frame_d;  // {stop, parity, d7..d0}; bit 0 is on the wire
    logic          nack_q, nack_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '1;
            nack_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (sync_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '1;
            nack_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            nack_q  <= nack_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        nack_d  = nack_q;
        ack_d   = ack_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    frame_d = {1'b1, ~^data_in, data_in};
                    cnt_d   = '0;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_REQ, S_SEND, S_RELEASE: begin
                // Timeout is checked first so it also wins over a same-cycle ack sample.
                if (cnt_q == TO_LAST) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == S_REQ) begin
                        if (fall_q) begin
                            idx_d   = '0;
                            state_d = S_SEND;
                        end
                    end else if (state_q == S_SEND) begin
                        if (fall_q) begin
                            if (idx_q == 4'd9) begin
                                // Fall after the stop bit: device drives the ack.
                                nack_d  = dat_sync_q;
                                state_d = S_RELEASE;
                            end else begin
                                idx_d   = idx_q + 1'b1;
                                frame_d = {1'b1, frame_q[9:1]};
                            end
                        end
                    end else begin
                        if (dat_sync_q && clk_filt_q) begin
                            ack_d   = ~nack_q;
                            err_d   = nack_q;
                            state_d = S_DONE;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so any reset releases the pins at once.
    always_comb begin
        busy              = (state_q != S_IDLE);
        rx_inhibit        = (state_q != S_IDLE);
        done              = (state_q == S_DONE);
        ack_ok            = ack_q;
        error             = err_q;
        ps2_clk_drive_low = (state_q == S_INHIBIT);
        ps2_dat_drive_low = 1'b0;
        case (state_q)
            S_INHIBIT: ps2_dat_drive_low = (cnt_q == INH_LAST);
            S_REQ:     ps2_dat_drive_low = 1'b1;
            S_SEND:    ps2_dat_drive_low = ~frame_q[0];
            default:   ps2_dat_drive_low = 1'b0;
        endcase
    end

endmodule
